// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, a one-deep skid entry,
// synchronous flush, load-use hazard detection and a saturating stall counter.
module id_ex_pipe_stage #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    dr1,
    input  logic [DW-1:0]    dr2,
    input  logic [DW-1:0]    sign,
    input  logic [DW-1:0]    cuatro,
    input  logic [RW-1:0]    AW,
    input  logic [RW-1:0]    Inm,
    input  logic [RW-1:0]    rs,
    input  logic [RW-1:0]    rt,
    input  logic [CW-1:0]    ctrl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    dr1_out,
    output logic [DW-1:0]    dr2_out,
    output logic [DW-1:0]    sign_out,
    output logic [DW-1:0]    cuatro_out,
    output logic [RW-1:0]    AW_out,
    output logic [RW-1:0]    Inm_out,
    output logic [CW-1:0]    ctrl_out,
    output logic             load_use,
    output logic [CNT_W-1:0] stall_cnt
);

    // Packed instruction layout (MSB..LSB): ctrl, Inm, AW, cuatro, sign, dr2, dr1
    localparam int PW = 4*DW + 2*RW + CW;

    logic [PW-1:0]    in_pkt;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             in_xfer;
    logic             main_free;

    assign in_pkt = {ctrl, Inm, AW, cuatro, sign, dr2, dr1};

    assign dr1_out    = main_q[DW-1:0];
    assign dr2_out    = main_q[2*DW-1:DW];
    assign sign_out   = main_q[3*DW-1:2*DW];
    assign cuatro_out = main_q[4*DW-1:3*DW];
    assign AW_out     = main_q[4*DW+RW-1:4*DW];
    assign Inm_out    = main_q[4*DW+2*RW-1:4*DW+RW];
    assign ctrl_out   = main_q[PW-1:PW-CW];
    assign out_valid  = out_valid_q;
    assign stall_cnt  = stall_q;

    // A load in the execute entry whose destination feeds the incoming instruction.
    assign load_use = in_valid & out_valid_q & ctrl_out[4] & (AW_out != '0)
                    & ((AW_out == rs) | (AW_out == rt));

    assign in_ready  = ~skid_valid_q & ~load_use & ~flush;
    assign in_xfer   = in_valid & in_ready;
    assign main_free = ~out_valid_q | out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        stall_d      = stall_q;

        if (flush) begin
            out_valid_d         = 1'b0;
            skid_valid_d        = 1'b0;
            main_d[PW-1 -: CW]  = '0;
        end else begin
            if (out_valid_q && !out_ready && stall_q != '1)
                stall_d = stall_q + CNT_W'(1);

            if (main_free) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    main_d      = in_pkt;
                    out_valid_d = 1'b1;
                end else begin
                    // Empty entry carries zero control so regwrite/ew never linger.
                    out_valid_d        = 1'b0;
                    main_d[PW-1 -: CW] = '0;
                end
            end else if (in_xfer) begin
                skid_d       = in_pkt;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed scenarios plus randomized traffic against
// a queue-based model of the two-entry stage.
module tb_id_ex_pipe_stage;

    typedef logic [153:0] pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1, out_ready_s = 1'b1;
    logic [31:0] dr1 = '0, dr2 = '0, sign = '0, cuatro = '0;
    logic [4:0]  AW = '0, Inm = '0, rs = '0, rt = '0;
    logic [15:0] ctrl = '0;

    logic        in_ready, out_valid, load_use;
    logic [31:0] dr1_out, dr2_out, sign_out, cuatro_out;
    logic [4:0]  AW_out, Inm_out;
    logic [15:0] ctrl_out, stall_cnt;

    logic        in_ready_s, out_valid_s, load_use_s;
    logic [31:0] dr1_out_s, dr2_out_s, sign_out_s, cuatro_out_s;
    logic [4:0]  AW_out_s, Inm_out_s;
    logic [15:0] ctrl_out_s;
    logic [3:0]  stall_cnt_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dr1(dr1), .dr2(dr2), .sign(sign), .cuatro(cuatro),
        .AW(AW), .Inm(Inm), .rs(rs), .rt(rt), .ctrl(ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .dr1_out(dr1_out), .dr2_out(dr2_out), .sign_out(sign_out), .cuatro_out(cuatro_out),
        .AW_out(AW_out), .Inm_out(Inm_out), .ctrl_out(ctrl_out),
        .load_use(load_use), .stall_cnt(stall_cnt)
    );

    id_ex_pipe_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .dr1(dr1), .dr2(dr2), .sign(sign), .cuatro(cuatro),
        .AW(AW), .Inm(Inm), .rs(rs), .rt(rt), .ctrl(ctrl), .flush(flush),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .dr1_out(dr1_out_s), .dr2_out(dr2_out_s), .sign_out(sign_out_s), .cuatro_out(cuatro_out_s),
        .AW_out(AW_out_s), .Inm_out(Inm_out_s), .ctrl_out(ctrl_out_s),
        .load_use(load_use_s), .stall_cnt(stall_cnt_s)
    );

    // Reference model: the stage is a FIFO of at most two instructions.
    pkt_t        q[$];
    logic [15:0] exp_cnt = '0;

    function automatic pkt_t cur_pkt();
        return {ctrl, Inm, AW, cuatro, sign, dr2, dr1};
    endfunction

    function automatic logic exp_load_use();
        logic [4:0] d;
        if (q.size() == 0 || !in_valid) return 1'b0;
        d = q[0][132:128];
        return q[0][142] && d != 5'd0 && (d == rs || d == rt);
    endfunction

    function automatic logic exp_in_ready();
        return q.size() < 2 && !exp_load_use() && !flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_cnt = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            logic take;
            take = in_valid && exp_in_ready();
            if (q.size() > 0 && !out_ready && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (take) q.push_back(cur_pkt());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic [4:0] aw,
                          input logic [15:0] c, input logic [4:0] s, input logic [4:0] t);
        in_valid = v; dr1 = d; dr2 = d ^ 32'hA5A5_A5A5; sign = ~d; cuatro = d + 32'd4;
        AW = aw; Inm = d[4:0]; ctrl = c; rs = s; rt = t;
    endtask

    task automatic apply_reset();
        set_in(1'b0, 32'h0, 5'd0, 16'h0, 5'd0, 5'd0);
        flush = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #3;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests_run++; if (ctrl_out !== 16'h0 || dr1_out !== 32'h0) begin tests_failed++; $display("FAIL reset_data got ctrl %h dr1 %h want 0", ctrl_out, dr1_out); end
        tests_run++; if (stall_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        rst = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        step();
    endtask

    task automatic test_streaming();
        logic [31:0] vals [4];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, vals[i], 5'd3, 16'h0002, 5'd0, 5'd0);
            #1;
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
            if (i == 0) begin
                tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_early_valid got %0b want 0", out_valid); end
            end
            step();
            tests_run++; if (out_valid !== 1'b1 || dr1_out !== vals[i]) begin tests_failed++; $display("FAIL stream_out[%0d] got v=%0b dr1=%h want v=1 dr1=%h", i, out_valid, dr1_out, vals[i]); end
        end
        in_valid = 1'b0;
        step();
        tests_run++; if (out_valid !== 1'b0 || ctrl_out !== 16'h0) begin tests_failed++; $display("FAIL stream_drain got v=%0b ctrl=%h want v=0 ctrl=0", out_valid, ctrl_out); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'hA, 5'd1, 16'h0, 5'd0, 5'd0);
        step();
        tests_run++; if (out_valid !== 1'b1 || dr1_out !== 32'hA) begin tests_failed++; $display("FAIL bp_A got v=%0b dr1=%h want v=1 dr1=a", out_valid, dr1_out); end
        set_in(1'b1, 32'hB, 5'd1, 16'h0, 5'd0, 5'd0);
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_B_ready got %0b want 1", in_ready); end
        step();
        set_in(1'b1, 32'hC, 5'd1, 16'h0, 5'd0, 5'd0);
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_C_blocked got %0b want 0", in_ready); end
        step();
        step();
        tests_run++; if (stall_cnt !== 16'd3 || dr1_out !== 32'hA) begin tests_failed++; $display("FAIL bp_held got cnt=%0d dr1=%h want cnt=3 dr1=a", stall_cnt, dr1_out); end
        out_ready = 1'b1;
        step();
        tests_run++; if (dr1_out !== 32'hB || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_order_B got v=%0b dr1=%h want b", out_valid, dr1_out); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_skid_drained got %0b want 1", in_ready); end
        step();
        tests_run++; if (dr1_out !== 32'hC || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_order_C got v=%0b dr1=%h want c", out_valid, dr1_out); end
        in_valid = 1'b0;
        step();
        tests_run++; if (out_valid !== 1'b0 || stall_cnt !== 16'd3) begin tests_failed++; $display("FAIL bp_end got v=%0b cnt=%0d want v=0 cnt=3", out_valid, stall_cnt); end
    endtask

    task automatic test_load_use();
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h100, 5'd5, 16'h0012, 5'd0, 5'd0);
        step();
        set_in(1'b1, 32'h200, 5'd7, 16'h0000, 5'd5, 5'd0);
        #1;
        tests_run++; if (load_use !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL lu_detect got lu=%0b rdy=%0b want lu=1 rdy=0", load_use, in_ready); end
        step();
        out_ready = 1'b1;
        #1;
        tests_run++; if (load_use !== 1'b1 || dr1_out !== 32'h100) begin tests_failed++; $display("FAIL lu_hold got lu=%0b dr1=%h want lu=1 dr1=100", load_use, dr1_out); end
        step();
        tests_run++; if (load_use !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL lu_clear got lu=%0b rdy=%0b v=%0b want 0 1 0", load_use, in_ready, out_valid); end
        step();
        tests_run++; if (out_valid !== 1'b1 || dr1_out !== 32'h200 || AW_out !== 5'd7) begin tests_failed++; $display("FAIL lu_accept got v=%0b dr1=%h aw=%0d want 1 200 7", out_valid, dr1_out, AW_out); end
        in_valid = 1'b0;
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h300, 5'd0, 16'h0012, 5'd0, 5'd0);
        step();
        set_in(1'b1, 32'h400, 5'd2, 16'h0000, 5'd0, 5'd0);
        #1;
        tests_run++; if (load_use !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL lu_zero_reg got lu=%0b rdy=%0b want 0 1", load_use, in_ready); end
        set_in(1'b1, 32'h400, 5'd2, 16'h0000, 5'd6, 5'd6);
        #1;
        tests_run++; if (load_use !== 1'b0) begin tests_failed++; $display("FAIL lu_no_match got %0b want 0", load_use); end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'hA1, 5'd1, 16'hFFFF, 5'd0, 5'd0);
        step();
        set_in(1'b1, 32'hB2, 5'd1, 16'h0002, 5'd0, 5'd0);
        step();
        set_in(1'b1, 32'hC3, 5'd1, 16'h0002, 5'd0, 5'd0);
        flush = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || ctrl_out !== 16'h0) begin tests_failed++; $display("FAIL flush_clear got v=%0b ctrl=%h want 0 0", out_valid, ctrl_out); end
        tests_run++; if (dr1_out !== 32'hA1 || stall_cnt !== 16'd1) begin tests_failed++; $display("FAIL flush_hold got dr1=%h cnt=%0d want a1 1", dr1_out, stall_cnt); end
        out_ready = 1'b1;
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_skid_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'hD1, 5'd4, 16'hFFFF, 5'd0, 5'd0);
        step();
        set_in(1'b1, 32'hD2, 5'd4, 16'hFFFF, 5'd0, 5'd0);
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0 || dr1_out !== 32'h0 || ctrl_out !== 16'h0 || stall_cnt !== 16'h0) begin
            tests_failed++; $display("FAIL async_rst got v=%0b dr1=%h ctrl=%h cnt=%0d want all 0", out_valid, dr1_out, ctrl_out, stall_cnt); end
        rst = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL async_rst_ready got %0b want 1", in_ready); end
        out_ready = 1'b1;
        step();
        tests_run++; if (out_valid !== 1'b0 || stall_cnt !== 16'h0) begin tests_failed++; $display("FAIL async_rst_lost got v=%0b cnt=%0d want 0 0", out_valid, stall_cnt); end
    endtask

    task automatic test_saturation();
        apply_reset();
        out_ready = 1'b1;
        out_ready_s = 1'b0;
        set_in(1'b1, 32'hE0, 5'd1, 16'h0, 5'd0, 5'd0);
        step();
        in_valid = 1'b0;
        repeat (20) step();
        tests_run++; if (stall_cnt_s !== 4'd15 || out_valid_s !== 1'b1) begin tests_failed++; $display("FAIL sat_cnt got cnt=%0d v=%0b want 15 1", stall_cnt_s, out_valid_s); end
        out_ready_s = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            logic ev, elu, erdy;
            in_valid  = ($urandom_range(0, 9) < 7);
            dr1 = $urandom; dr2 = $urandom; sign = $urandom; cuatro = $urandom;
            AW  = 5'($urandom_range(0, 3));
            Inm = 5'($urandom);
            ctrl = 16'($urandom);
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            #2;
            ev   = q.size() > 0;
            elu  = exp_load_use();
            erdy = exp_in_ready();
            tests_run++; if (out_valid !== ev) begin tests_failed++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, out_valid, ev); end
            tests_run++; if (load_use !== elu) begin tests_failed++; $display("FAIL rnd_load_use[%0d] got %0b want %0b", n, load_use, elu); end
            tests_run++; if (in_ready !== erdy) begin tests_failed++; $display("FAIL rnd_in_ready[%0d] got %0b want %0b", n, in_ready, erdy); end
            tests_run++; if (stall_cnt !== exp_cnt) begin tests_failed++; $display("FAIL rnd_stall[%0d] got %0d want %0d", n, stall_cnt, exp_cnt); end
            if (ev) begin
                tests_run++; if ({ctrl_out, Inm_out, AW_out, cuatro_out, sign_out, dr2_out, dr1_out} !== q[0]) begin
                    tests_failed++; $display("FAIL rnd_data[%0d] got dr1=%h ctrl=%h want dr1=%h ctrl=%h", n, dr1_out, ctrl_out, q[0][31:0], q[0][153:138]); end
            end else begin
                tests_run++; if (ctrl_out !== 16'h0) begin tests_failed++; $display("FAIL rnd_ctrl_idle[%0d] got %h want 0", n, ctrl_out); end
            end
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_load_use();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage for the MIPS-style datapath, between decode/register-file read and execute.
- Generalises the plain clocked ID/EX register with three additions:
  - valid/ready handshake backed by a 2-entry skid buffer (main + skid);
  - synchronous flush for bubble insertion on branch/jump;
  - load-use hazard detection plus a saturating stall-cycle counter.
- Throughput is one instruction per cycle when downstream is ready.

Parameters:
- DW, 32, width of dr1/dr2/sign/cuatro data paths
- RW, 5, width of register-address fields (AW, Inm, rs, rt)
- CW, 16, control-bus width; must be >= 16
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle (transfer = in_valid & in_ready)
- dr1, dr2, sign, cuatro  in  DW each  operands, sign-extended immediate, PC+4
- AW, Inm  in  RW each  destination register, shamt/immediate field
- rs, rt  in  RW each  source registers of the incoming instruction (hazard check only, not stored)
- ctrl  in  CW  bit0 regdst, 1 regwrite, 2 memtoreg, 3 alusrc, 4 er, 5 ew, 6 pcsrc, [9:7] aluop, [15:10] sel, upper bits passed through
- flush  in  1  kill all held instructions
- out_valid  out  1  execute entry holds an instruction
- out_ready  in  1  execute consumes (transfer = out_valid & out_ready)
- dr1_out, dr2_out, sign_out, cuatro_out  out  DW each  registered copies
- AW_out, Inm_out  out  RW each  registered copies
- ctrl_out  out  CW  registered control
- load_use  out  1  hazard flag to hazard unit / PC-write gating
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready

Behaviour:
- Reset (async, immediate):
  - out_valid = 0, skid_valid = 0.
  - All data outputs, ctrl_out and stall_cnt = 0.
  - in_ready = 1 once rst deasserts.
- Combinational outputs:
  - load_use = in_valid & out_valid & ctrl_out[4] & (AW_out != 0) & ((AW_out == rs) | (AW_out == rt)).
  - in_ready = !skid_valid & !load_use & !flush.
- Latency: an input accepted into an empty stage appears on the *_out ports with out_valid = 1 on the next rising edge.
- Main entry update, per edge, first matching rule wins:
  - flush: out_valid = 0 and ctrl_out = 0; data outputs hold.
  - out entry empty or consumed, skid_valid = 1: main loads skid; skid_valid = 0.
  - out entry empty or consumed, skid empty, input transfer: main loads input.
  - out entry empty or consumed, no source: out_valid = 0; data holds; ctrl_out = 0, so regwrite and ew are never stale-high.
  - out entry held (out_valid & !out_ready), input transfer: input goes to skid; skid_valid = 1.
- Skid-full backpressure: skid_valid = 1 forces in_ready = 0. A third instruction is never accepted.
- Ordering: strict FIFO; skid always drains before new input.
- Simultaneous out consume and input transfer with skid empty: main loads input in the same edge, with no bubble.
- Flush:
  - Synchronous, highest priority.
  - Clears out_valid and skid_valid.
  - Forces in_ready = 0, so same-cycle input is dropped.
  - No counter increment that cycle.
- load_use:
  - Holds decode while the load sits unconsumed in the stage.
  - Clears automatically once the load leaves (out consumed) or is flushed.
  - AW_out == 0 never triggers.
- stall_cnt:
  - Increments on each edge where out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W − 1; no wrap.
  - Cleared only by rst.
- Reset mid-operation: every held instruction is lost; no partial write-back.

Test Plan:
- Streaming: out_ready = 1; send 4 instructions on consecutive cycles, dr1 = 0x11..0x44 -> out_valid rises 1 cycle after the first; dr1_out = 0x11, 0x22, 0x33, 0x44 in consecutive cycles; in_ready stays 1.
- Backpressure: out_ready = 0; send A, B, C -> A in main, B in skid, in_ready = 0 while C is held. Raise out_ready -> A, B, C delivered in order, nothing lost or duplicated; stall_cnt equals the number of held cycles.
- Load-use: hold in main AW_out = 5 with ctrl_out[4] = 1; present in_valid with rs = 5 -> load_use = 1, in_ready = 0. After out consume -> load_use = 0 and the instruction is accepted. Repeat with AW_out = 0 -> load_use never 1.
- Flush: main and skid full, in_valid = 1, flush pulse -> next cycle out_valid = 0, ctrl_out = 0, skid empty; the input presented during flush never appears at the output.
- Async reset mid-stream: assert rst between clock edges -> outputs go to 0 immediately; after release in_ready = 1 and stall_cnt = 0.
- Saturation: CNT_W = 4, hold out_ready = 0 for 20 cycles -> stall_cnt stops at 15.
